// File: rtl/mips150_mem_pkg.sv
// Shared encodings for the MIPS150 unified-memory path: arbiter states and the
// decoder's MemWrite / Mask codes.
package mips150_mem_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DATA  = 2'd1;
    localparam logic [1:0] ST_FETCH = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [1:0] MW_LOAD = 2'b00;
    localparam logic [1:0] MW_SB   = 2'b01;
    localparam logic [1:0] MW_SH   = 2'b10;
    localparam logic [1:0] MW_SW   = 2'b11;

    localparam logic [2:0] MASK_LB  = 3'b000;
    localparam logic [2:0] MASK_LH  = 3'b001;
    localparam logic [2:0] MASK_LW  = 3'b010;
    localparam logic [2:0] MASK_LBU = 3'b011;
    localparam logic [2:0] MASK_LHU = 3'b100;

endpackage

// File: rtl/mips150_mem_align.sv
// Byte-lane store generation, load extract/extend and misalignment detection
// for one data access. Purely combinational.
module mips150_mem_align
    import mips150_mem_pkg::*;
(
    input  logic [1:0]  memwrite,
    input  logic [2:0]  mask,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  we,
    output logic [31:0] wlanes,
    output logic [31:0] rext,
    output logic        misaligned
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        we     = '0;
        wlanes = wdata;
        case (memwrite)
            MW_SB: begin
                we     = 4'b0001 << addr;
                wlanes = {4{wdata[7:0]}};
            end
            MW_SH: begin
                we     = addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata[15:0]}};
            end
            MW_SW:   we = 4'b1111;
            default: we = '0;
        endcase
    end

    always_comb begin
        case (addr)
            2'd0:    rbyte = rword[7:0];
            2'd1:    rbyte = rword[15:8];
            2'd2:    rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase
        rhalf = addr[1] ? rword[31:16] : rword[15:0];
    end

    // Undefined Mask codes fall through to the raw word.
    always_comb begin
        case (mask)
            MASK_LB:  rext = {{24{rbyte[7]}}, rbyte};
            MASK_LBU: rext = {24'd0, rbyte};
            MASK_LH:  rext = {{16{rhalf[15]}}, rhalf};
            MASK_LHU: rext = {16'd0, rhalf};
            default:  rext = rword;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (memwrite)
            MW_SH: misaligned = addr[0];
            MW_SW: misaligned = |addr;
            MW_LOAD: begin
                if (mask == MASK_LH || mask == MASK_LHU)
                    misaligned = addr[0];
                else if (mask == MASK_LW)
                    misaligned = |addr;
            end
            default: misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips150_mem_arbiter.sv
// Shares the single-ported unified memory between instruction fetch and
// load/store, with a bounded data-priority run to keep fetch from starving.
module mips150_mem_arbiter
    import mips150_mem_pkg::*;
#(
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        dm_req,
    input  logic [1:0]  dm_memwrite,
    input  logic [2:0]  dm_mask,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,
    output logic        err_misaligned,
    output logic        stall,
    output logic        mem_req,
    output logic [3:0]  mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned RUN_W = $clog2(MAX_DATA_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

    logic [1:0]       state;
    logic [RUN_W-1:0] run;

    logic [3:0]  al_we;
    logic [31:0] al_wlanes;
    logic [31:0] al_rext;
    logic        al_misaligned;
    logic        data_grant;

    mips150_mem_align u_align (
        .memwrite   (dm_memwrite),
        .mask       (dm_mask),
        .addr       (dm_addr[1:0]),
        .wdata      (dm_wdata),
        .rword      (mem_rdata),
        .we         (al_we),
        .wlanes     (al_wlanes),
        .rext       (al_rext),
        .misaligned (al_misaligned)
    );

    assign data_grant = dm_req & (~if_req | (run < RUN_MAX));
    assign stall      = (if_req & ~if_valid) | (dm_req & ~dm_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            run            <= '0;
            mem_req        <= 1'b0;
            mem_we         <= '0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            if_rdata       <= '0;
            dm_rdata       <= '0;
            if_valid       <= 1'b0;
            dm_valid       <= 1'b0;
            err_misaligned <= 1'b0;
        end else begin
            if_valid       <= 1'b0;
            dm_valid       <= 1'b0;
            err_misaligned <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (data_grant) begin
                        if (if_req)
                            run <= (run == RUN_MAX) ? run : run + 1'b1;
                        else
                            run <= '0;
                        if (al_misaligned) begin
                            state <= ST_RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_addr  <= dm_addr[31:2];
                            mem_we    <= al_we;
                            mem_wdata <= al_wlanes;
                            state     <= ST_DATA;
                        end
                    end else if (if_req) begin
                        run      <= '0;
                        mem_req  <= 1'b1;
                        mem_addr <= if_addr[31:2];
                        mem_we   <= '0;
                        state    <= ST_FETCH;
                    end
                end
                ST_DATA: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        dm_rdata <= (dm_memwrite == MW_LOAD) ? al_rext : '0;
                        dm_valid <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        if_rdata <= mem_rdata;
                        if_valid <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    dm_rdata       <= '0;
                    dm_valid       <= 1'b1;
                    err_misaligned <= 1'b1;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mips150_mem_arbiter.md
# mips150_mem_arbiter

Sequencing controller for the single-ported unified memory behind the MIPS150 core. Shares the memory between the instruction-fetch requester and the load/store requester, drives byte-lane write enables from the decoder's 2-bit MemWrite code, and extracts and extends load data from the decoder's 3-bit Mask code. Asserts `stall` to the pipeline while any access is outstanding. Sits between the core datapath/control and the memory model or block-RAM wrapper.

## Interface
- `MAX_DATA_RUN`, 4: consecutive data grants allowed while a fetch is waiting.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request; held until `if_valid`.
- `if_addr` in 32: fetch byte address; bits [1:0] ignored.
- `if_rdata` out 32: fetched word, valid with `if_valid`.
- `if_valid` out 1: one-cycle fetch-completion pulse.
- `dm_req` in 1: data request; operands held stable until `dm_valid`.
- `dm_memwrite` in 2: 00 load, 01 SB, 10 SH, 11 SW.
- `dm_mask` in 3: load type: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU.
- `dm_addr` in 32: data byte address.
- `dm_wdata` in 32: store data, right-justified.
- `dm_rdata` out 32: extended load result, valid with `dm_valid`.
- `dm_valid` out 1: one-cycle data-completion pulse (loads and stores).
- `err_misaligned` out 1: pulses with `dm_valid` when the access was misaligned.
- `stall` out 1: `(if_req & ~if_valid) | (dm_req & ~dm_valid)`. Combinational.
- `mem_req` out 1: memory request; held until `mem_ack`.
- `mem_we` out 4: byte-lane enables; lane 0 = bits [7:0] (little-endian); 0000 = read.
- `mem_addr` out 30: word address.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: read word, valid when `mem_ack` is high.
- `mem_ack` in 1: completion; may assert in the first `mem_req` cycle; arbitrary latency.

## Operation
- FSM states: IDLE, DATA, FETCH, RESP.
- IDLE, data grant: taken when `dm_req & (~if_req | run < MAX_DATA_RUN)`.
  - Aligned access: latch `mem_addr`, `mem_we`, `mem_wdata`; set `mem_req`; go to DATA.
  - Misaligned access: go to RESP with no memory access.
- IDLE, fetch grant: otherwise, if `if_req`, latch `if_addr[31:2]`; set `mem_req`, `mem_we`=0; go to FETCH.
- DATA or FETCH: hold all `mem_*` outputs stable until `mem_ack`. On the ack edge:
  - clear `mem_req`;
  - register the result into `dm_rdata` or `if_rdata`;
  - pulse the matching valid;
  - return to IDLE.
- RESP: pulse `dm_valid` and `err_misaligned` with `dm_rdata`=0; return to IDLE.
- Fairness counter `run`:
  - increments (saturating at MAX) on a data grant while `if_req` is high;
  - clears on a data grant with `if_req` low;
  - clears on every fetch grant.
- Store lanes:
  - SB: `we = 0001 << addr[1:0]`, `wdata = {4{b}}`.
  - SH: `we = addr[1] ? 1100 : 0011`, `wdata = {2{h}}`.
  - SW: `we = 1111`.
- Load extract:
  - LB/LBU: select byte `addr[1:0]`, then sign- or zero-extend.
  - LH/LHU: select half `addr[1]`, then sign- or zero-extend.
  - LW and undefined Mask codes 101–111: raw word.
- Misalignment: halfword ops with `addr[0]=1`; word ops with `addr[1:0]≠0`.
- `mem_ack` outside DATA/FETCH is ignored.

## Timing
- Reset values: state IDLE, `run`=0, all registered outputs 0 (`mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata`, `if_valid`, `dm_valid`, `err_misaligned`).
- Latency, request sampled in cycle 0:
  - `mem_req` high in cycle 1.
  - With ack in cycle 1, valid is high in cycle 2.
  - Total latency is 2 + (ack wait) cycles.
- Throughput: at most one access per 2 cycles. IDLE occupies the valid cycle; the next grant is sampled in that cycle.
- Misaligned path: valid exactly 2 cycles after the request is sampled.
- Simultaneous requests in IDLE: data wins unless `run == MAX_DATA_RUN`.
- Reset mid-access: asynchronous return to IDLE. Any pending valid is dropped. A late `mem_ack` is ignored.

## Structure
- Shared package/header `mips150_mem_pkg` holds:
  - state encodings;
  - MemWrite codes (LOAD/SB/SH/SW);
  - Mask codes (LB/LH/LW/LBU/LHU), shared with the decoder.
- Combinational sub-module `mips150_mem_align` does store lane/enable generation, load extract/extend and misalignment detection. The arbiter holds only the FSM, the counter and the registers.

## Test plan
- SB, `addr=0x1003`, `wdata=0x000000AB`, ack in cycle 1 → `mem_we=1000`, `mem_wdata=0xABABABAB`, `mem_addr=0x400`, `dm_valid` in cycle 2.
- LB at `addr+2`, `mem_rdata=0x0080FF00` → `dm_rdata=0xFFFFFF80`. LHU `addr[1]=1`, same word → `0x00000080`.
- LW `addr=0x6` → no `mem_req`; `dm_valid`, `err_misaligned` and `dm_rdata=0` in cycle 2.
- `if_req` and `dm_req` held high continuously, `MAX_DATA_RUN=4`, ack in 1 cycle → grants D,D,D,D,F,D…; `stall` high throughout.
- Ack delayed 5 cycles → `mem_*` outputs stable for all 6 request cycles; `if_valid` exactly one cycle.
- `rst` pulsed while in DATA, then `mem_ack` asserted → all outputs 0, no `dm_valid`, next `dm_req` served normally.
